// File: rtl/ws2812_pkg.sv
// -----------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812 pixel serializer and bit driver:
//   - serializer FSM state encoding
//   - pixel word width and bit-index helpers
//   - default latch/reset gap length
//   - bit-cell timing counts shared with the bit driver (200 MHz clock)
// -----------------------------------------------------------------------------
package ws2812_pkg;

   // One GRB pixel word, sent MSB first.
   localparam int          PIXEL_W      = 24;
   localparam int          BIT_IDX_W    = 5;
   localparam logic [4:0]  LAST_BIT_IDX = 5'(PIXEL_W - 1);

   // Idle time after the last bit: 60 us at 200 MHz (the LEDs latch after 50 us).
   localparam logic [15:0] CNT_RESET_GAP_DFLT = 16'd12000;

   // Bit-cell timing at 200 MHz. A '0' is 0.35 us high then 1.35 us low,
   // a '1' is 1.35 us high then 0.35 us low; the whole cell is 1.70 us.
   localparam logic [15:0] CNT_0P35_US = 16'd70;
   localparam logic [15:0] CNT_1P35_US = 16'd270;
   localparam logic [15:0] CNT_1P70_US = 16'd340;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      SEND  = 3'd3,
      WAIT  = 3'd4,
      GAP   = 3'd5,
      DONE  = 3'd6
   } ser_state_e;

endpackage

// File: rtl/ws2812_pixel_ser.sv
// -----------------------------------------------------------------------------
// ws2812_pixel_ser
// Reads GRB pixel words from the frame RAM and serializes them MSB first into
// single bits for the WS2812 bit driver. Each bit is offered with a one-cycle
// bit_rdy_out pulse and held on bit_data_out until the driver returns
// bit_done_in. After the last pixel the line idles for CNT_RESET_GAP cycles,
// then frame_done_out pulses for one cycle.
//
// Ports
//   clk_in           system clock (200 MHz)
//   rst_in           synchronous, active-high reset
//   start_in         one-cycle pulse, starts a frame when idle
//   pixel_cnt_in     pixels in the frame, sampled on an accepted start
//   ram_rd_en_out    frame RAM read strobe
//   ram_rd_addr_out  frame RAM read address
//   ram_rd_data_in   GRB word, valid one cycle after ram_rd_en_out
//   bit_rdy_out      one-cycle pulse: bit_data_out valid, driver may start
//   bit_data_out     current bit, stable until the matching bit_done_in
//   bit_done_in      one-cycle pulse from the driver: current bit finished
//   busy_out         high from accepted start until frame_done_out
//   frame_done_out   one-cycle pulse at the end of the reset gap
// -----------------------------------------------------------------------------
module ws2812_pixel_ser
   import ws2812_pkg::*;
#(
   parameter int          ADDR_W        = 8,
   // Must be at least 1.
   parameter logic [15:0] CNT_RESET_GAP = CNT_RESET_GAP_DFLT
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   input  logic [ADDR_W-1:0] pixel_cnt_in,
   output logic              ram_rd_en_out,
   output logic [ADDR_W-1:0] ram_rd_addr_out,
   input  logic [23:0]       ram_rd_data_in,
   output logic              bit_rdy_out,
   output logic              bit_data_out,
   input  logic              bit_done_in,
   output logic              busy_out,
   output logic              frame_done_out
);

   ser_state_e           state_q;
   ser_state_e           state_d;
   logic [ADDR_W-1:0]    cnt_q;
   logic [ADDR_W-1:0]    pix_idx_q;
   logic [PIXEL_W-1:0]   shreg_q;
   logic [BIT_IDX_W-1:0] bit_idx_q;
   logic [15:0]          gap_cnt_q;

   logic                 last_bit;
   logic                 more_pix;
   logic                 gap_end;

   assign last_bit = (bit_idx_q == LAST_BIT_IDX);
   // Compared one bit wider so pix_idx_q + 1 cannot wrap to zero.
   assign more_pix = ({1'b0, pix_idx_q} + (ADDR_W + 1)'(1)) < {1'b0, cnt_q};
   assign gap_end  = (gap_cnt_q == CNT_RESET_GAP - 16'd1);

   // Address tracks the pixel index; the strobe alone marks a real read.
   assign ram_rd_addr_out = pix_idx_q;
   // The MSB is the bit on offer; it is forced low outside SEND/WAIT so the
   // line reads 0 during the gap and between frames.
   assign bit_data_out = ((state_q == SEND) || (state_q == WAIT)) ? shreg_q[PIXEL_W-1] : 1'b0;

   // Next-state and strobe decode.
   always_comb begin
      // NOTE: every output gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      state_d        = state_q;
      ram_rd_en_out  = 1'b0;
      bit_rdy_out    = 1'b0;
      busy_out       = 1'b1;
      frame_done_out = 1'b0;

      case (state_q)
         IDLE: begin
            busy_out = 1'b0;
            if (start_in) begin
               state_d = (pixel_cnt_in == '0) ? GAP : FETCH;
            end
         end
         FETCH: begin
            ram_rd_en_out = 1'b1;
            state_d       = LOAD;
         end
         LOAD: begin
            state_d = SEND;
         end
         SEND: begin
            bit_rdy_out = 1'b1;
            state_d     = WAIT;
         end
         WAIT: begin
            if (bit_done_in) begin
               if (!last_bit) begin
                  state_d = SEND;
               end else if (more_pix) begin
                  state_d = FETCH;
               end else begin
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (gap_end) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy_out       = 1'b0;
            frame_done_out = 1'b1;
            state_d        = IDLE;
         end
         default: begin
            busy_out = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   // State register and datapath.
   always_ff @(posedge clk_in) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (rst_in) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pix_idx_q <= '0;
         shreg_q   <= '0;
         bit_idx_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q <= state_d;

         case (state_q)
            IDLE: begin
               if (start_in) begin
                  cnt_q     <= pixel_cnt_in;
                  pix_idx_q <= '0;
                  gap_cnt_q <= '0;
               end
            end
            LOAD: begin
               shreg_q   <= ram_rd_data_in;
               bit_idx_q <= '0;
            end
            WAIT: begin
               if (bit_done_in) begin
                  if (!last_bit) begin
                     shreg_q   <= {shreg_q[PIXEL_W-2:0], 1'b0};
                     bit_idx_q <= bit_idx_q + 5'd1;
                  end else if (more_pix) begin
                     pix_idx_q <= pix_idx_q + ADDR_W'(1);
                  end
               end
            end
            GAP: begin
               if (!gap_end) begin
                  gap_cnt_q <= gap_cnt_q + 16'd1;
               end
            end
            DONE: begin
               pix_idx_q <= '0;
               bit_idx_q <= '0;
               gap_cnt_q <= '0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/ws2812_pixel_ser.md
Name: ws2812_pixel_ser

Overview:
- Upstream stage of the WS2812 bit driver. Reads 24-bit GRB pixel words from the frame RAM and serializes them MSB-first into single bits.
- Each bit is offered through the bit_rdy/bit_data handshake; the next bit is issued only after the driver's bit_done pulse.
- After the last pixel it holds the line idle for the WS2812 latch/reset gap, then signals frame completion.

Parameters:
- ADDR_W, 8, width of pixel address and pixel count.
- CNT_RESET_GAP, 16'd12000, idle cycles after the last bit (60 us at 200 MHz; must exceed 50 us).

Ports:
- clk_in  input  1  system clock (200 MHz).
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  one-cycle pulse; begins a frame when idle.
- pixel_cnt_in  input  ADDR_W  number of pixels in the frame; sampled on an accepted start_in.
- ram_rd_en_out  output  1  frame RAM read strobe.
- ram_rd_addr_out  output  ADDR_W  frame RAM read address.
- ram_rd_data_in  input  24  GRB word, valid exactly 1 cycle after ram_rd_en_out.
- bit_rdy_out  output  1  one-cycle pulse: bit_data_out is valid, driver may start.
- bit_data_out  output  1  current bit; held stable from bit_rdy_out until the matching bit_done_in.
- bit_done_in  input  1  one-cycle pulse from the driver: current bit finished.
- busy_out  output  1  high from accepted start until frame_done_out.
- frame_done_out  output  1  one-cycle pulse at end of the reset gap.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; shift register, bit index, pixel index and gap counter cleared. Reset mid-frame aborts immediately; no further bit_rdy_out.
- IDLE:
  - start_in=1: latch pixel_cnt_in into cnt_q, pix_idx=0, busy_out=1.
  - If pixel_cnt_in==0, go to GAP; otherwise go to FETCH.
  - start_in while busy is ignored.
- FETCH (1 cycle): ram_rd_en_out=1, ram_rd_addr_out=pix_idx, then LOAD.
- LOAD (1 cycle): shreg<=ram_rd_data_in, bit_idx=0, then SEND.
- SEND (1 cycle): bit_rdy_out=1, bit_data_out=shreg[23], then WAIT.
- WAIT: hold bit_data_out. On bit_done_in:
  - bit_idx<23: shift shreg left by 1, bit_idx+1, go to SEND.
  - bit_idx==23 and pix_idx<cnt_q-1: pix_idx+1, go to FETCH.
  - Otherwise (last bit of last pixel): bit_data_out=0, go to GAP.
- Latency and ordering:
  - start→first bit_rdy_out: 3 cycles (FETCH, LOAD, SEND).
  - bit_done_in→next bit_rdy_out: 1 cycle within a pixel, 3 cycles across pixels.
  - bit_done_in outside WAIT is ignored.
- GAP:
  - Counter runs 0..CNT_RESET_GAP-1, then go to DONE.
  - bit_rdy_out stays 0 throughout; the driver therefore holds its data line low.
- DONE (1 cycle): frame_done_out=1, busy_out=0, clear counters, go to IDLE. start_in in this cycle is ignored; start_in in the next cycle is accepted.
- Widths:
  - bit_idx is 5 bits.
  - Gap counter is 16 bits, no wrap.
  - pix_idx never exceeds cnt_q-1, so the maximum pixel_cnt_in is 2^ADDR_W-1 addressed pixels; 0 means an empty frame (reset gap only).
- A frame with 1 pixel emits exactly 24 bit_rdy_out pulses.

Decomposition:
- Shared package ws2812_pkg:
  - FSM state encoding (IDLE, FETCH, LOAD, SEND, WAIT, GAP, DONE).
  - PIXEL_W=24.
  - CNT_RESET_GAP default.
  - Timing constants shared with the bit driver (0.35/1.35/1.70 us counts).
- No sub-module needed. The gap counter stays inline. A top wrapper ws2812_chain instantiates this block plus the bit driver.

Test Plan:
- Single pixel: pixel_cnt_in=1, RAM[0]=24'hA5_0F_81, driver model returns bit_done_in 340 cycles after each rdy → 24 rdy pulses, bit_data_out sequence 1010_0101_0000_1111_1000_0001; busy_out high throughout.
- Three pixels: RAM[0..2]=24'hFFFFFF/24'h000000/24'h800001, pixel_cnt_in=3 → 72 bits, reads only at addr 0,1,2; 3-cycle gap between pixels after done.
- Reset gap: after the last bit_done_in → frame_done_out exactly CNT_RESET_GAP+1 cycles later (use CNT_RESET_GAP=16 in sim); no rdy during the gap; an empty frame (pixel_cnt_in=0) gives done after the gap with zero reads.
- Handshake stall: hold bit_done_in low 1000 cycles → bit_data_out stable, no extra rdy; a spurious bit_done_in during SEND/GAP has no effect.
- Start while busy: assert start_in mid-frame and in the DONE cycle → ignored; start in the cycle after DONE → a new frame starts, first rdy 3 cycles later.
- Reset mid-frame: rst_in during WAIT of pixel 1 bit 7 → next cycle all outputs 0, IDLE; a subsequent start replays from pixel 0 bit 23.
